alu_arbiter: RTL and testbench

//  Shares one alu_unit instance between two requesters (issue ports 0 and 1).
//  - Round-robin grant with valid/ready on each request port.
//  - Tracks the ALU's 1-cycle registered latency and routes each result and tag

---
 rtl/alu_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered-latency alu_unit between two issue ports.
//   Round-robin grant with valid/ready on each request port. The ALU result,
//   valid one cycle after issue, is routed with its tag into a 1-entry response
//   buffer per port with valid/ready back-pressure.
//
// Ports
//   i_clk, i_rst                     clock, async active-high reset
//   i_reqN_valid / o_reqN_ready      request handshake (ready = grant N)
//   i_reqN_funct/alt/x/y/tag         op fields of port N
//   o_rspN_valid / i_rspN_ready      response handshake of port N
//   o_rspN_data / o_rspN_tag         buffered result and originating tag
//   o_alu_funct/alt/x/y              drive to the shared alu_unit
//   i_alu_out                        alu_unit result, valid 1 cycle after issue
//   o_idle                           nothing in flight and both buffers empty
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // request port 0
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [2:0]       i_req0_funct,
  input  logic             i_req0_alt,
  input  logic [XLEN-1:0]  i_req0_x,
  input  logic [XLEN-1:0]  i_req0_y,
  input  logic [TAG_W-1:0] i_req0_tag,
  // request port 1
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [2:0]       i_req1_funct,
  input  logic             i_req1_alt,
  input  logic [XLEN-1:0]  i_req1_x,
  input  logic [XLEN-1:0]  i_req1_y,
  input  logic [TAG_W-1:0] i_req1_tag,
  // response port 0
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [XLEN-1:0]  o_rsp0_data,
  output logic [TAG_W-1:0] o_rsp0_tag,
  // response port 1
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [XLEN-1:0]  o_rsp1_data,
  output logic [TAG_W-1:0] o_rsp1_tag,
  // shared ALU
  output logic [2:0]       o_alu_funct,
  output logic             o_alu_alt,
  output logic [XLEN-1:0]  o_alu_x,
  output logic [XLEN-1:0]  o_alu_y,
  input  logic [XLEN-1:0]  i_alu_out,
  // status
  output logic             o_idle
);

  logic             r_rr_ptr;      // port that wins when both are eligible
  logic             r_inf_valid;   // an op was issued last cycle
  logic             r_inf_port;    // its originating port
  logic [TAG_W-1:0] r_inf_tag;     // its tag
  logic             r_rsp0_valid;
  logic [XLEN-1:0]  r_rsp0_data;
  logic [TAG_W-1:0] r_rsp0_tag;
  logic             r_rsp1_valid;
  logic [XLEN-1:0]  r_rsp1_data;
  logic [TAG_W-1:0] r_rsp1_tag;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [TAG_W-1:0] w_gnt_tag;
  logic             w_load0;
  logic             w_load1;

  // Eligibility and round-robin grant. A port is excluded while its previous
  // op is still in the ALU, so its response buffer can never be overrun. No
  // grant is given while reset is asserted, since such an op would be lost.
  always_comb begin
    w_elig0 = 1'b0;
    w_elig1 = 1'b0;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    if (i_rst) begin
      w_elig0 = 1'b0;
      w_elig1 = 1'b0;
    end else begin
      w_elig0 = i_req0_valid && !(r_inf_valid && (r_inf_port == 1'b0)) &&
                (!r_rsp0_valid || i_rsp0_ready);
      w_elig1 = i_req1_valid && !(r_inf_valid && (r_inf_port == 1'b1)) &&
                (!r_rsp1_valid || i_rsp1_ready);
    end
    if (w_elig0 && w_elig1) begin
      w_gnt0 = (r_rr_ptr == 1'b0);
      w_gnt1 = (r_rr_ptr == 1'b1);
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
  end

  // ALU operand mux: granted port drives the ALU, otherwise all zero.
  always_comb begin
    o_alu_funct = 3'd0;
    o_alu_alt   = 1'b0;
    o_alu_x     = {XLEN{1'b0}};
    o_alu_y     = {XLEN{1'b0}};
    w_gnt_tag   = {TAG_W{1'b0}};
    case ({w_gnt1, w_gnt0})
      2'b01: begin
        o_alu_funct = i_req0_funct;
        o_alu_alt   = i_req0_alt;
        o_alu_x     = i_req0_x;
        o_alu_y     = i_req0_y;
        w_gnt_tag   = i_req0_tag;
      end
      2'b10: begin
        o_alu_funct = i_req1_funct;
        o_alu_alt   = i_req1_alt;
        o_alu_x     = i_req1_x;
        o_alu_y     = i_req1_y;
        w_gnt_tag   = i_req1_tag;
      end
      default: begin
        o_alu_funct = 3'd0;
        o_alu_alt   = 1'b0;
        o_alu_x     = {XLEN{1'b0}};
        o_alu_y     = {XLEN{1'b0}};
        w_gnt_tag   = {TAG_W{1'b0}};
      end
    endcase
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // The in-flight entry says which buffer i_alu_out belongs to this cycle.
  assign w_load0 = r_inf_valid && (r_inf_port == 1'b0);
  assign w_load1 = r_inf_valid && (r_inf_port == 1'b1);

  // Round-robin pointer and in-flight tracking register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= 1'b0;
      r_inf_valid <= 1'b0;
      r_inf_port  <= 1'b0;
      r_inf_tag   <= {TAG_W{1'b0}};
    end else begin
      if (w_gnt0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_rr_ptr <= 1'b0;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      r_inf_valid <= w_gnt0 || w_gnt1;
      r_inf_port  <= w_gnt1;
      r_inf_tag   <= w_gnt_tag;
    end
  end

  // Response buffer 0: a load beats a same-edge drain so valid stays high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= {XLEN{1'b0}};
      r_rsp0_tag   <= {TAG_W{1'b0}};
    end else if (w_load0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= i_alu_out;
      r_rsp0_tag   <= r_inf_tag;
    end else if (r_rsp0_valid && i_rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= r_rsp0_valid;
    end
  end

  // Response buffer 1: same policy as buffer 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= {XLEN{1'b0}};
      r_rsp1_tag   <= {TAG_W{1'b0}};
    end else if (w_load1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= i_alu_out;
      r_rsp1_tag   <= r_inf_tag;
    end else if (r_rsp1_valid && i_rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp1_valid <= r_rsp1_valid;
    end
  end

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp0_data  = r_rsp0_data;
  assign o_rsp0_tag   = r_rsp0_tag;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp1_data  = r_rsp1_data;
  assign o_rsp1_tag   = r_rsp1_tag;
  assign o_idle       = !r_inf_valid && !r_rsp0_valid && !r_rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A behavioural registered ALU stands in for
//   alu_unit (funct: 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR,
//   7 AND). Inputs change on the falling edge; outputs are sampled 1 time unit
//   later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_alt;
  logic [2:0]  req0_funct;
  logic [31:0] req0_x, req0_y;
  logic [3:0]  req0_tag;
  logic        req1_valid, req1_ready, req1_alt;
  logic [2:0]  req1_funct;
  logic [31:0] req1_x, req1_y;
  logic [3:0]  req1_tag;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic [3:0]  rsp0_tag;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic [3:0]  rsp1_tag;
  logic [2:0]  alu_funct;
  logic        alu_alt;
  logic [31:0] alu_x, alu_y, alu_out;
  logic        idle;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_funct(req0_funct),
    .i_req0_alt(req0_alt), .i_req0_x(req0_x), .i_req0_y(req0_y), .i_req0_tag(req0_tag),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_funct(req1_funct),
    .i_req1_alt(req1_alt), .i_req1_x(req1_x), .i_req1_y(req1_y), .i_req1_tag(req1_tag),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
    .o_rsp0_tag(rsp0_tag),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
    .o_rsp1_tag(rsp1_tag),
    .o_alu_funct(alu_funct), .o_alu_alt(alu_alt), .o_alu_x(alu_x), .o_alu_y(alu_y),
    .i_alu_out(alu_out), .o_idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu_unit: result registered on the rising edge, not reset.
  always_ff @(posedge clk) begin
    case (alu_funct)
      3'd0: alu_out <= alu_alt ? (alu_x - alu_y) : (alu_x + alu_y);
      3'd1: alu_out <= alu_x << alu_y[4:0];
      3'd2: alu_out <= {31'd0, ($signed(alu_x) < $signed(alu_y))};
      3'd3: alu_out <= {31'd0, (alu_x < alu_y)};
      3'd4: alu_out <= alu_x ^ alu_y;
      3'd5: alu_out <= alu_alt ? ($signed(alu_x) >>> alu_y[4:0]) : (alu_x >> alu_y[4:0]);
      3'd6: alu_out <= alu_x | alu_y;
      default: alu_out <= alu_x & alu_y;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [2:0] f, input logic a,
                      input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
    req0_valid = v; req0_funct = f; req0_alt = a; req0_x = x; req0_y = y; req0_tag = t;
  endtask

  task automatic set1(input logic v, input logic [2:0] f, input logic a,
                      input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
    req1_valid = v; req1_funct = f; req1_alt = a; req1_x = x; req1_y = y; req1_tag = t;
  endtask

  logic [31:0] exp_d [0:7];
  logic [3:0]  exp_t [0:7];
  int          c0, c1;
  logic        g0;

  initial begin
    rst = 1'b1;
    set0(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_tag", {28'd0, rsp1_tag}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single ADD on port 0, response two cycles after accept
    set0(1'b1, 3'd0, 1'b0, 32'd5, 32'd3, 4'd1);
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_alu_x", alu_x, 32'd5);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
    chk("t1_busy", {31'd0, idle}, 32'd0);
    tick();
    #1;
    chk("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("t1_rsp0_data", rsp0_data, 32'd8);
    chk("t1_rsp0_tag", {28'd0, rsp0_tag}, 32'd1);
    tick();
    #1;
    chk("t1_drained", {31'd0, rsp0_valid}, 32'd0);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // 6: SLT on port 1 while port 0 is quiet
    set1(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd7);
    #1;
    chk("t6_ready1", {31'd0, req1_ready}, 32'd1);
    chk("t6_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    chk("t6_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("t6_rsp1_data", rsp1_data, 32'd1);
    chk("t6_rsp1_tag", {28'd0, rsp1_tag}, 32'd7);
    chk("t6_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    tick();

    // 2: both ports valid every cycle -> strict alternation starting at port 0
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      set0(1'b1, 3'd0, 1'b0, 32'(10 + c0), 32'd1, 4'(c0));
      set1(1'b1, 3'd0, 1'b0, 32'(20 + c1), 32'd2, 4'(8 + c1));
      #1;
      g0 = ((i % 2) == 0);
      chk("t2_ready0", {31'd0, req0_ready}, {31'd0, g0});
      chk("t2_ready1", {31'd0, req1_ready}, {31'd0, !g0});
      chk("t2_alu_x", alu_x, g0 ? 32'(10 + c0) : 32'(20 + c1));
      exp_d[i] = g0 ? 32'(11 + c0) : 32'(22 + c1);
      exp_t[i] = g0 ? 4'(c0) : 4'(8 + c1);
      if (i >= 2) begin
        if ((i % 2) == 0) begin
          chk("t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
          chk("t2_rsp0_data", rsp0_data, exp_d[i-2]);
          chk("t2_rsp0_tag", {28'd0, rsp0_tag}, {28'd0, exp_t[i-2]});
          chk("t2_rsp1_gap", {31'd0, rsp1_valid}, 32'd0);
        end else begin
          chk("t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
          chk("t2_rsp1_data", rsp1_data, exp_d[i-2]);
          chk("t2_rsp1_tag", {28'd0, rsp1_tag}, {28'd0, exp_t[i-2]});
          chk("t2_rsp0_gap", {31'd0, rsp0_valid}, 32'd0);
        end
      end else begin
        chk("t2_rsp_start", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      if (g0) c0++;
      else c1++;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("t2_tail0_data", rsp0_data, exp_d[6]);
    chk("t2_tail0_valid", {31'd0, rsp0_valid}, 32'd1);
    tick();
    #1;
    chk("t2_tail1_data", rsp1_data, exp_d[7]);
    tick();
    tick();
    #1;
    chk("t2_idle", {31'd0, idle}, 32'd1);

    // 3: port 0 back-pressured; result held, port 0 blocked, port 1 served
    rsp0_ready = 1'b0;
    set0(1'b1, 3'd0, 1'b1, 32'd3, 32'd5, 4'd2);
    set1(1'b1, 3'd0, 1'b0, 32'd100, 32'd0, 4'd0);
    #1;
    chk("t3_s0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t3_s0_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    set0(1'b1, 3'd0, 1'b0, 32'd9, 32'd1, 4'd3);
    #1;
    chk("t3_s1_ready0", {31'd0, req0_ready}, 32'd0);
    chk("t3_s1_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    set1(1'b1, 3'd0, 1'b0, 32'd101, 32'd0, 4'd1);
    #1;
    chk("t3_s2_rsp0_data", rsp0_data, 32'hFFFF_FFFE);
    chk("t3_s2_rsp0_tag", {28'd0, rsp0_tag}, 32'd2);
    chk("t3_s2_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    #1;
    chk("t3_s3_ready1", {31'd0, req1_ready}, 32'd1);
    chk("t3_s3_ready0", {31'd0, req0_ready}, 32'd0);
    chk("t3_s3_rsp1_data", rsp1_data, 32'd100);
    chk("t3_s3_rsp0_held", rsp0_data, 32'hFFFF_FFFE);
    tick();
    set1(1'b1, 3'd0, 1'b0, 32'd102, 32'd0, 4'd2);
    #1;
    chk("t3_s4_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("t3_s4_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("t3_s4_rsp0_held", rsp0_data, 32'hFFFF_FFFE);
    tick();
    rsp0_ready = 1'b1;
    #1;
    chk("t3_s5_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t3_s5_ready1", {31'd0, req1_ready}, 32'd0);
    chk("t3_s5_rsp1_data", rsp1_data, 32'd101);
    chk("t3_s5_alu_x", alu_x, 32'd9);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t3_s6_rsp0_clear", {31'd0, rsp0_valid}, 32'd0);
    chk("t3_s6_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("t3_s7_rsp0_data", rsp0_data, 32'd10);
    chk("t3_s7_rsp0_tag", {28'd0, rsp0_tag}, 32'd3);
    tick();
    #1;
    chk("t3_s8_rsp1_data", rsp1_data, 32'd102);
    tick();
    tick();
    #1;
    chk("t3_idle", {31'd0, idle}, 32'd1);

    // 4: only port 0 valid -> one accept every second cycle
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, 3'd0, 1'b0, 32'(50 + i / 2), 32'd0, 4'(i / 2));
      #1;
      chk("t4_ready0", {31'd0, req0_ready}, {31'd0, ((i % 2) == 0)});
      chk("t4_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ((i >= 2) && ((i % 2) == 0))});
      if ((i >= 2) && ((i % 2) == 0)) begin
        chk("t4_rsp0_data", rsp0_data, 32'(50 + (i - 2) / 2));
      end
      tick();
    end
    req0_valid = 1'b0;
    #1;
    chk("t4_tail_data", rsp0_data, 32'd52);
    chk("t4_tail_tag", {28'd0, rsp0_tag}, 32'd2);
    tick();
    tick();

    // 5: reset the cycle after a grant drops the in-flight op and buffers
    rsp1_ready = 1'b0;
    set1(1'b1, 3'd0, 1'b0, 32'd2, 32'd2, 4'd6);
    #1;
    chk("t5_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    set0(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 4'd5);
    #1;
    chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t5_pre_rsp1", rsp1_data, 32'd4);
    rst = 1'b1;
    #1;
    chk("t5_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("t5_rst_data", rsp1_data, 32'd0);
    chk("t5_rst_idle", {31'd0, idle}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t5_no_stale_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("t5_idle", {31'd0, idle}, 32'd1);
    end
    rsp1_ready = 1'b1;
    set0(1'b1, 3'd0, 1'b0, 32'd7, 32'd7, 4'd1);
    set1(1'b1, 3'd0, 1'b0, 32'd8, 32'd8, 4'd2);
    #1;
    chk("t5_first_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t5_first_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    #1;
    chk("t5_post_data", rsp0_data, 32'd14);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
